msg_uart_tx: RTL and testbench



---
 rtl/msg_uart_pkg.sv | 21 ++
 rtl/msg_fifo.sv | 63 ++++++
 rtl/msg_uart_tx.sv | 153 +++++++++++++++
 tb/tb_msg_uart_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_uart_pkg.sv
// rtl/msg_uart_pkg.sv - shared types, defaults and helpers for the message UART transmitter
package msg_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int         DEF_CLK_HZ     = 50_000_000;
    localparam int         DEF_BAUD       = 115200;
    localparam int         DEF_FIFO_DEPTH = 16;
    localparam logic [7:0] DEF_TERM_CHAR  = 8'h23;

    // Whole clock cycles per UART bit; the fractional part is dropped.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// rtl/msg_fifo.sv - synchronous first-word-fall-through character FIFO
module msg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // Guard both ports so a stray request can never corrupt the pointers.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/msg_uart_tx.sv
// rtl/msg_uart_tx.sv - buffered 8N1 UART transmitter that flags message terminators
module msg_uart_tx
    import msg_uart_pkg::*;
#(
    parameter int         CLK_HZ     = DEF_CLK_HZ,
    parameter int         BAUD       = DEF_BAUD,
    parameter int         FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [7:0] TERM_CHAR  = DEF_TERM_CHAR
) (
    input  logic                        clk_50M,
    input  logic                        rst,
    input  logic [7:0]                  msg,
    input  logic                        msg_valid,
    output logic                        msg_ready,
    output logic                        tx,
    output logic                        tx_busy,
    output logic                        msg_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int               CPB      = clks_per_bit(CLK_HZ, BAUD);
    localparam int               CNT_W    = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       char_q, char_d;
    logic             tx_q, tx_d;
    logic             msg_done_q, msg_done_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic             fifo_pop;
    logic             baud_last;

    // Ready is taken from the registered full flag only, never from this cycle's pop.
    assign msg_ready = !fifo_full;

    msg_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_50M),
        .rst   (rst),
        .push  (msg_valid && msg_ready),
        .pop   (fifo_pop),
        .din   (msg),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_last = (cnt_q == CNT_LAST);

    // Next-state logic: frame sequencing, baud counting, and the registered line/pulse values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        char_d   = char_q;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    char_d   = fifo_dout;
                    bit_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_last) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit with no idle gap.
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        char_d   = fifo_dout;
                        bit_d    = '0;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // The line is computed from the next state so the register is already correct on entry.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        // Raise the pulse on the edge that enters the last stop-bit cycle of a terminator frame.
        msg_done_d = (state_d == STOP) && (cnt_d == CNT_LAST) && (char_d == TERM_CHAR);
    end

    // State and datapath registers; reset forces the line idle immediately.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            char_q     <= '0;
            tx_q       <= 1'b1;
            msg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            char_q     <= char_d;
            tx_q       <= tx_d;
            msg_done_q <= msg_done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_busy  = (state_q != IDLE);
    assign msg_done = msg_done_q;

endmodule

// File: tb/tb_msg_uart_tx.sv
// tb/tb_msg_uart_tx.sv - scoreboard bench for the message UART transmitter
module tb_msg_uart_tx;

    localparam logic [7:0] TERM = 8'h23;

    logic       clk_50M = 1'b0;
    logic       rst;
    logic [7:0] msg;
    logic       msg_valid;
    logic       msg_ready;
    logic       tx;
    logic       tx_busy;
    logic       msg_done;
    logic [2:0] fifo_count;

    msg_uart_tx #(
        .CLK_HZ     (1000),
        .BAUD       (100),
        .FIFO_DEPTH (4),
        .TERM_CHAR  (TERM)
    ) dut (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .msg        (msg),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .msg_done   (msg_done),
        .fifo_count (fifo_count)
    );

    always #5 clk_50M = ~clk_50M;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sb[$];
    int         frame_starts[$];

    int         cyc_n = 0;
    int         mcyc = 0;
    int         busy_run = 0;
    int         last_busy_run = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    bit         in_frame = 0;
    bit         last_stop = 0;
    logic [7:0] rx_byte = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Line decoder: checks bit boundaries against the scoreboard head and pops at each stop bit end.
    always @(negedge clk_50M) begin
        bit         at_last;
        int         k;
        logic       eb;
        logic [7:0] hb;
        cyc_n++;
        last_stop = 0;
        if (rst) begin
            in_frame = 0;
            busy_run = 0;
        end else begin
            if (tx_busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_busy_run = busy_run;
                busy_run = 0;
            end
            if (!in_frame && tx === 1'b0) begin
                in_frame = 1;
                mcyc = 0;
                rx_byte = '0;
                frame_starts.push_back(cyc_n);
                check_eq("busy_at_start", tx_busy, 1);
            end else if (in_frame) begin
                mcyc++;
            end
            at_last = in_frame && (mcyc == 99);
            if (in_frame) begin
                if ((mcyc % 10 == 0 || mcyc % 10 == 9) && sb.size() > 0) begin
                    k = mcyc / 10;
                    hb = sb[0];
                    if (k == 0) eb = 1'b0;
                    else if (k <= 8) eb = hb[k-1];
                    else eb = 1'b1;
                    check_eq("tx_bit_edge", tx, eb);
                end
                if (mcyc % 10 == 5 && mcyc >= 15 && mcyc <= 85) begin
                    rx_byte[(mcyc - 15) / 10] = tx;
                end
                if (at_last) begin
                    check_eq("busy_at_stop", tx_busy, 1);
                    check_eq("msg_done", msg_done, rx_byte == TERM);
                    if (msg_done === 1'b1) begin
                        done_cnt++;
                        done_cyc = cyc_n;
                    end
                    check_eq("sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        check_eq("rx_char", rx_byte, sb.pop_front());
                    end
                    in_frame = 0;
                    last_stop = 1;
                end
            end
            if (!at_last && msg_done !== 1'b0) begin
                check_eq("msg_done_stray", msg_done, 0);
            end
        end
    end

    task automatic send(input logic [7:0] b, output int waits);
        msg = b;
        msg_valid = 1'b1;
        waits = 0;
        while (msg_ready !== 1'b1 && waits < 2000) begin
            @(negedge clk_50M); #1;
            waits++;
        end
        check_eq("send_ready", msg_ready, 1);
        if (msg_ready === 1'b1) sb.push_back(b);
        @(negedge clk_50M); #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || tx_busy !== 1'b0 || fifo_count != 0) && n < 5000) begin
            @(negedge clk_50M); #1;
            n++;
        end
        check_eq("drain", (sb.size() == 0) && (tx_busy === 1'b0) && (fifo_count == 0), 1);
        repeat (3) @(negedge clk_50M);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int ws[6];
        int base;
        int d0;
        int n;
        logic [7:0] burst[6];
        logic [7:0] term_msg[4];

        rst = 1'b1;
        msg = '0;
        msg_valid = 1'b0;
        #1;
        check_eq("rst_tx", tx, 1);
        check_eq("rst_busy", tx_busy, 0);
        check_eq("rst_done", msg_done, 0);
        check_eq("rst_ready", msg_ready, 1);
        check_eq("rst_count", fifo_count, 0);
        repeat (3) @(negedge clk_50M);
        rst = 1'b0;
        #1;

        // Idle line for 1000 cycles
        repeat (1000) @(negedge clk_50M);
        #1;
        check_eq("idle_frames", frame_starts.size(), 0);
        check_eq("idle_tx", tx, 1);
        check_eq("idle_ready", msg_ready, 1);
        check_eq("idle_done", done_cnt, 0);

        // Single character with latency check
        base = frame_starts.size();
        d0 = done_cnt;
        send(8'h46, w);
        msg_valid = 1'b0;
        check_eq("t1_count_push", fifo_count, 1);
        check_eq("t1_tx_before", tx, 1);
        @(negedge clk_50M); #1;
        check_eq("t1_tx_start", tx, 0);
        check_eq("t1_busy", tx_busy, 1);
        check_eq("t1_count_pop", fifo_count, 0);
        wait_idle();
        check_eq("t1_busy_len", last_busy_run, 100);
        check_eq("t1_frames", frame_starts.size() - base, 1);
        check_eq("t1_no_done", done_cnt - d0, 0);

        // Burst of six with back-pressure
        burst = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        base = frame_starts.size();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                check_eq("t2_full_count", fifo_count, 4);
                check_eq("t2_ready_low", msg_ready, 0);
            end
            send(burst[i], ws[i]);
        end
        msg_valid = 1'b0;
        check_eq("t2_no_wait_first5", ws[0] + ws[1] + ws[2] + ws[3] + ws[4], 0);
        check_eq("t2_sixth_stalled", ws[5] > 0, 1);
        wait_idle();
        check_eq("t2_frames", frame_starts.size() - base, 6);
        for (int i = base + 1; i < frame_starts.size(); i++) begin
            check_eq("t2_gap", frame_starts[i] - frame_starts[i-1], 100);
        end
        check_eq("t2_busy_len", last_busy_run, 600);

        // Terminated message
        term_msg = '{8'h53, 8'h55, 8'h31, TERM};
        base = frame_starts.size();
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            send(term_msg[i], w);
        end
        msg_valid = 1'b0;
        wait_idle();
        check_eq("t3_done_count", done_cnt - d0, 1);
        check_eq("t3_done_cycle", done_cyc - frame_starts[base], 399);
        check_eq("t3_busy_len", last_busy_run, 400);

        // Push on the same edge as the stop-to-start pop
        base = frame_starts.size();
        send(8'h58, w);
        send(8'h59, w);
        msg_valid = 1'b0;
        n = 0;
        while (!last_stop && n < 500) begin
            @(negedge clk_50M); #1;
            n++;
        end
        check_eq("t4_found_stop", last_stop, 1);
        check_eq("t4_count_before", fifo_count, 1);
        send(8'h5A, w);
        msg_valid = 1'b0;
        check_eq("t4_count_after", fifo_count, 1);
        check_eq("t4_next_start", tx, 0);
        wait_idle();
        check_eq("t4_frames", frame_starts.size() - base, 3);

        // Reset during data bit 3 with two characters buffered
        send(8'h50, w);
        send(8'h51, w);
        send(8'h52, w);
        msg_valid = 1'b0;
        check_eq("t5_buffered", fifo_count, 2);
        n = 0;
        while (!(in_frame && mcyc == 45) && n < 500) begin
            @(negedge clk_50M); #1;
            n++;
        end
        check_eq("t5_in_bit3", in_frame && mcyc == 45, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5_tx", tx, 1);
        check_eq("t5_busy", tx_busy, 0);
        check_eq("t5_count", fifo_count, 0);
        check_eq("t5_ready", msg_ready, 1);
        sb.delete();
        repeat (3) @(negedge clk_50M);
        rst = 1'b0;
        #1;
        base = frame_starts.size();
        repeat (300) @(negedge clk_50M);
        #1;
        check_eq("t5_quiet_frames", frame_starts.size() - base, 0);
        check_eq("t5_quiet_tx", tx, 1);
        send(8'hA5, w);
        msg_valid = 1'b0;
        wait_idle();
        check_eq("t5_resume_frames", frame_starts.size() - base, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
